// File: rtl/mem_if_pkg.sv
// Shared definitions for both ends of the data-memory request interface:
// the responder FSM states, the bus widths and the error-flag encoding.
package mem_if_pkg;

   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   // Value carried on rsp_err; the initiator decodes the same encoding.
   typedef enum logic {
      ERR_OK    = 1'b0,
      ERR_RANGE = 1'b1
   } err_e;

endpackage

// File: rtl/byte_en_ram.sv
// Synchronous single-port DEPTH x 32 RAM with per-byte write enables and a
// registered read port that holds its value while en is low.
module byte_en_ram
   import mem_if_pkg::*;
#(
   parameter int DEPTH = 2048,
   parameter int AW    = 11
) (
   input  logic              clock,
   input  logic              en,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [BE_W-1:0]   be,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array and its read register have no reset; resetting them would turn the array into flops.
   always_ff @(posedge clock) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BE_W; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the data-memory interface: accepts one request, waits
// WAIT_STATES cycles, performs one array access and holds the response.
module data_mem_responder
   import mem_if_pkg::*;
#(
   parameter int ADDR_W      = 11,
   parameter int DEPTH       = 2048,
   parameter int WAIT_STATES = 0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam int         RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_e              state;
   logic [3:0]          wait_cnt;
   logic                write_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [BE_W-1:0]     be_q;
   logic                rd_sel;
   logic                in_range;
   logic                ram_en;
   logic [DATA_W-1:0]   ram_rdata;

   // Unsigned compare over the full address width, so aliasing addresses never hit the array.
   assign in_range = (32'(addr_q) < 32'(DEPTH));
   assign ram_en   = (state == ACCESS) && in_range;

   byte_en_ram #(
      .DEPTH (DEPTH),
      .AW    (RAM_AW)
   ) u_ram (
      .clock (clock),
      .en    (ram_en),
      .we    (write_q),
      .addr  (addr_q[RAM_AW-1:0]),
      .wdata (wdata_q),
      .be    (be_q),
      .rdata (ram_rdata)
   );

   // The RAM read register is only loaded in ACCESS, so it already holds the
   // load result for the whole response; rd_sel forces zero for stores/errors.
   assign rsp_rdata = rd_sel ? ram_rdata : '0;

   // NOTE: all state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= ERR_OK;
         rd_sel    <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  write_q   <= req_write;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  be_q      <= req_be;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (WAIT_STATES > 0) begin
                     state    <= WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) state <= ACCESS;
               else                  wait_cnt <= wait_cnt - 4'd1;
            end
            ACCESS: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= in_range ? ERR_OK : ERR_RANGE;
               rd_sel    <= !write_q && in_range;
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
